// File: rtl/lsu.sv
// Load/store unit: request/acknowledge word bus with byte enables, extended load return.
// Latency: 2 cycles best case (accept -> BUS -> RESP); error without bus access responds 1 cycle after accept.
// Backpressure: stall holds the PC while a request is pending or on the bus; bus waits for mem_ack up to TIMEOUT_CYCLES.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned half/word accesses instead of aligning them).
module lsu #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    // Counter value seen on the last BUS cycle before the access is abandoned.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        err_q;

    logic [1:0]  size;
    logic        illegal;
    logic        bad;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign size = req_funct3[1:0];

    // Decode the incoming request: legality, byte enables and lane-replicated store data.
    always_comb begin
        if (req_we)
            illegal = req_funct3[2] | (size == 2'b11);
        else
            illegal = (size == 2'b11) | (req_funct3[2] & req_funct3[1]);
`ifdef LSU_MISALIGN_TRAP_EN
        bad = illegal
            | ((size == 2'b01) & req_addr[0])
            | ((size == 2'b10) & (req_addr[1:0] != 2'b00));
`else
        bad = illegal;
`endif
        case (size)
            2'b00: begin
                be_d    = 4'b0001 << req_addr[1:0];
                wdata_d = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{req_wdata[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = req_wdata;
            end
        endcase
    end

    // Pick the addressed lane(s) out of the bus word and extend per the latched funct3.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; an ack on the final counted cycle beats the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = bad ? RESP : BUS;
            BUS:  if (mem_ack || (cnt == TO_LAST)) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, bus registers, cycle counter and response data.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt       <= 8'd0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            err_q     <= 1'b0;
            rsp_rdata <= 32'd0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_be    <= 4'd0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    cnt       <= 8'd0;
                    f3_q      <= req_funct3;
                    off_q     <= req_addr[1:0];
                    err_q     <= bad;
                    rsp_rdata <= 32'd0;
                    if (!bad) begin
                        mem_we    <= req_we;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_wdata <= wdata_d;
                        mem_be    <= be_d;
                    end
                end
                BUS: begin
                    cnt <= cnt + 8'd1;
                    if (mem_ack)
                        rsp_rdata <= mem_we ? 32'd0 : ld_data;
                    else if (cnt == TO_LAST)
                        err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are decoded from state so reset removes them at once.
    always_comb begin
        mem_req   = (state == BUS);
        rsp_valid = (state == RESP);
        err       = (state == RESP) & err_q;
        stall     = n_rst & (((state == IDLE) & req_valid) | (state == BUS));
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a scoreboard of expected bus and response values.
// Bus side is modelled by the bench: ack after a programmed number of BUS cycles.
// Covers loads/stores of every width, illegal funct3, misalignment, timeout and reset during BUS.
module tb_lsu;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        stall, rsp_valid, err, mem_req, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          req_cycles;
        int          stall_cycles;
    } rsp_exp_t;

    bus_exp_t bus_q[$];
    rsp_exp_t rsp_q[$];

    int total = 0;
    int passed = 0;

    lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .n_rst(n_rst),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Issue one request at the current negedge, play the bus for it and score the result.
    // ack_at = BUS cycle on which mem_ack is driven (0 = never).
    task automatic run(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int ack_at, input logic [31:0] rd);
        int req_cnt = 0;
        int stall_cnt = 0;
        bit done = 0;
        bus_exp_t be_e;
        rsp_exp_t rs_e;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        mem_rdata  = rd;
        #1;
        for (int c = 0; c < 40 && !done; c++) begin
            if (stall) stall_cnt++;
            if (mem_req) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    if (bus_q.size() == 0) begin
                        check({tag, " unexpected mem_req"}, 32'(mem_req), 32'd0);
                    end else begin
                        be_e = bus_q.pop_front();
                        check({tag, " mem_we"}, 32'(mem_we), 32'(be_e.we));
                        check({tag, " mem_addr"}, mem_addr, be_e.addr);
                        check({tag, " mem_be"}, 32'(mem_be), 32'(be_e.be));
                        if (be_e.we) check({tag, " mem_wdata"}, mem_wdata, be_e.wdata);
                    end
                end
                mem_ack = (req_cnt == ack_at);
            end else begin
                mem_ack = 1'b0;
            end
            if (rsp_valid) begin
                rs_e = rsp_q.pop_front();
                check({tag, " rsp_rdata"}, rsp_rdata, rs_e.rdata);
                check({tag, " err"}, 32'(err), 32'(rs_e.err));
                check({tag, " mem_req cycles"}, 32'(req_cnt), 32'(rs_e.req_cycles));
                check({tag, " stall cycles"}, 32'(stall_cnt), 32'(rs_e.stall_cycles));
                req_valid = 1'b0;
                done = 1;
            end
            @(negedge clk);
            #1;
        end
        mem_ack = 1'b0;
        req_valid = 1'b0;
        if (!done) begin
            check({tag, " rsp_valid within budget"}, 32'd0, 32'd1);
            void'(rsp_q.pop_front());
        end
        check({tag, " rsp_valid one cycle"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic exp_bus(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        bus_exp_t e;
        e.we = we; e.addr = a; e.wdata = wd; e.be = be;
        bus_q.push_back(e);
    endtask

    task automatic exp_rsp(input logic [31:0] rd, input logic e, input int reqc, input int stc);
        rsp_exp_t r;
        r.rdata = rd; r.err = e; r.req_cycles = reqc; r.stall_cycles = stc;
        rsp_q.push_back(r);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst stall", 32'(stall), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_rdata", rsp_rdata, 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst mem_req", 32'(mem_req), 32'd0);
        check("rst mem_we", 32'(mem_we), 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        check("rst mem_be", 32'(mem_be), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // LW, ack on 3rd BUS cycle
        exp_bus(1'b0, 32'h100, 32'h0, 4'b1111);
        exp_rsp(32'hDEADBEEF, 1'b0, 3, 4);
        run("LW", 1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF);

        // Byte/half loads with extension
        exp_bus(1'b0, 32'h100, 32'h0, 4'b1000);
        exp_rsp(32'hFFFFFF80, 1'b0, 1, 2);
        run("LB", 1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80123456);
        exp_bus(1'b0, 32'h100, 32'h0, 4'b1000);
        exp_rsp(32'h00000080, 1'b0, 1, 2);
        run("LBU", 1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80123456);
        exp_bus(1'b0, 32'h100, 32'h0, 4'b1100);
        exp_rsp(32'hFFFF8012, 1'b0, 2, 3);
        run("LH", 1'b0, 3'b001, 32'h102, 32'h0, 2, 32'h80123456);
        exp_bus(1'b0, 32'h200, 32'h0, 4'b0011);
        exp_rsp(32'h00003456, 1'b0, 1, 2);
        run("LHU", 1'b0, 3'b101, 32'h200, 32'h0, 1, 32'h80123456);
        exp_bus(1'b0, 32'h100, 32'h0, 4'b0010);
        exp_rsp(32'h00000034, 1'b0, 1, 2);
        run("LB1", 1'b0, 3'b000, 32'h101, 32'h0, 1, 32'h80123456);

        // Stores
        exp_bus(1'b1, 32'h100, 32'hABABABAB, 4'b0100);
        exp_rsp(32'h0, 1'b0, 1, 2);
        run("SB", 1'b1, 3'b000, 32'h102, 32'h000000AB, 1, 32'h55555555);
        exp_bus(1'b1, 32'h300, 32'h12341234, 4'b1100);
        exp_rsp(32'h0, 1'b0, 2, 3);
        run("SH", 1'b1, 3'b001, 32'h302, 32'hFFFF1234, 2, 32'h55555555);
        exp_bus(1'b1, 32'h104, 32'hCAFEF00D, 4'b1111);
        exp_rsp(32'h0, 1'b0, 1, 2);
        run("SW", 1'b1, 3'b010, 32'h104, 32'hCAFEF00D, 1, 32'h55555555);

        // Illegal funct3: no bus access, response one cycle after acceptance
        exp_rsp(32'h0, 1'b1, 0, 1);
        run("LD011", 1'b0, 3'b011, 32'h100, 32'h0, 1, 32'h12345678);
        exp_rsp(32'h0, 1'b1, 0, 1);
        run("LD110", 1'b0, 3'b110, 32'h100, 32'h0, 1, 32'h12345678);
        exp_rsp(32'h0, 1'b1, 0, 1);
        run("ST100", 1'b1, 3'b100, 32'h100, 32'h0, 1, 32'h12345678);

        // Misaligned half and word
`ifdef LSU_MISALIGN_TRAP_EN
        exp_rsp(32'h0, 1'b1, 0, 1);
        run("LH mis", 1'b0, 3'b001, 32'h101, 32'h0, 1, 32'h80123456);
        exp_rsp(32'h0, 1'b1, 0, 1);
        run("SW mis", 1'b1, 3'b010, 32'h103, 32'h11223344, 1, 32'h0);
`else
        exp_bus(1'b0, 32'h100, 32'h0, 4'b0011);
        exp_rsp(32'h00003456, 1'b0, 1, 2);
        run("LH mis", 1'b0, 3'b001, 32'h101, 32'h0, 1, 32'h80123456);
        exp_bus(1'b1, 32'h100, 32'h11223344, 4'b1111);
        exp_rsp(32'h0, 1'b0, 1, 2);
        run("SW mis", 1'b1, 3'b010, 32'h103, 32'h11223344, 1, 32'h0);
`endif

        // Timeout (TIMEOUT_CYCLES=4) and ack on the final cycle
        exp_bus(1'b0, 32'h400, 32'h0, 4'b1111);
        exp_rsp(32'h0, 1'b1, 4, 5);
        run("TO", 1'b0, 3'b010, 32'h400, 32'h0, 0, 32'hFFFFFFFF);
        exp_bus(1'b0, 32'h400, 32'h0, 4'b1111);
        exp_rsp(32'h87654321, 1'b0, 4, 5);
        run("TO ack", 1'b0, 3'b010, 32'h400, 32'h0, 4, 32'h87654321);

        // mem_ack outside BUS is ignored
        mem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("idle ack rsp_valid", 32'(rsp_valid), 32'd0);
        check("idle ack mem_req", 32'(mem_req), 32'd0);
        mem_ack = 1'b0;

        // Reset during BUS
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h500;
        @(negedge clk);
        #1;
        check("pre-rst mem_req", 32'(mem_req), 32'd1);
        n_rst = 1'b0;
        #1;
        check("rst BUS mem_req", 32'(mem_req), 32'd0);
        check("rst BUS stall", 32'(stall), 32'd0);
        check("rst BUS rsp_valid", 32'(rsp_valid), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("post-rst mem_req", 32'(mem_req), 32'd0);
            check("post-rst rsp_valid", 32'(rsp_valid), 32'd0);
            check("post-rst stall", 32'(stall), 32'd0);
        end

        // Normal operation after reset
        exp_bus(1'b0, 32'h600, 32'h0, 4'b1111);
        exp_rsp(32'h0BADF00D, 1'b0, 1, 2);
        run("LW post-rst", 1'b0, 3'b010, 32'h600, 32'h0, 1, 32'h0BADF00D);

        check("bus queue drained", 32'(bus_q.size()), 32'd0);
        check("rsp queue drained", 32'(rsp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the core's execute stage and the data-memory bus. Takes the ALU result as the address and `rd2` as store data. Runs a request/acknowledge transaction on a word-wide memory bus with byte enables and returns sign- or zero-extended load data for the writeback mux. Stalls the core's PC update while a transaction is outstanding.

## Interface
- `TIMEOUT_CYCLES`, 16: maximum number of cycles spent in BUS without `mem_ack` before the access is aborted with an error; legal range 1–255.
- `clk  in  1`: clock; all state changes on the rising edge.
- `n_rst  in  1`: reset, asynchronous, active-low.
- `req_valid  in  1`: a load or store is presented; the core holds it until `rsp_valid`.
- `req_we  in  1`: 1 = store, 0 = load.
- `req_funct3  in  3`: RISC-V funct3.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `req_addr  in  32`: byte address from the ALU.
- `req_wdata  in  32`: store data, in the low bytes.
- `stall  out  1`: the core must hold the PC.
- `rsp_valid  out  1`: one-cycle completion pulse.
- `rsp_rdata  out  32`: extended load data; 0 for stores and for errors.
- `err  out  1`: one-cycle pulse, coincident with `rsp_valid`; signals an illegal funct3, a timeout, or a misaligned access (the latter only when `LSU_MISALIGN_TRAP_EN` is defined).
- `mem_req  out  1`: bus request.
- `mem_we  out  1`: bus write.
- `mem_addr  out  32`: word-aligned address; bits [1:0] are always 0.
- `mem_wdata  out  32`: lane-replicated write data.
- `mem_be  out  4`: byte enables; bit i enables lane i (bits [8i+7:8i]).
- `mem_ack  in  1`: bus acknowledge; read data is valid in the same cycle.
- `mem_rdata  in  32`: bus read data.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE, `req_valid`=0: stay in IDLE.
- IDLE, `req_valid`=1:
  - Latch the request.
  - Illegal funct3 (loads 011/110/111; stores 1xx, 011) goes to RESP with the error flag set and no bus access.
  - Otherwise load the bus registers and go to BUS.
- BUS:
  - `mem_req`=1. `mem_we`, `mem_addr`, `mem_wdata` and `mem_be` stay constant.
  - The cycle counter increments every cycle.
  - `mem_ack`=1: capture the extended read data, go to RESP.
  - Counter reaches `TIMEOUT_CYCLES` with no ack: go to RESP with the error flag set and `rsp_rdata` = 0.
- RESP: `rsp_valid`=1 and `err` = error flag for exactly one cycle, then IDLE. A request presented during RESP is not accepted.
- Byte enables and write data:
  - Byte access: `mem_be` = 1 << addr[1:0]; `mem_wdata` = byte replicated ×4.
  - Half access: `mem_be` = addr[1] ? 1100 : 0011; `mem_wdata` = half replicated ×2.
  - Word access: `mem_be` = 1111; `mem_wdata` = `req_wdata`.
  - Loads drive `mem_be` with the same rule.
- Load extraction:
  - Byte: `mem_rdata` >> (8·addr[1:0]), taking bits [7:0].
  - Half: `mem_rdata` >> (16·addr[1]), taking bits [15:0].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word unchanged.
- `mem_ack` outside BUS is ignored.

## Timing
- Reset values: state IDLE, counter 0, and `stall`, `rsp_valid`, `rsp_rdata`, `err`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be` all 0.
- Reset asserted during BUS drops `mem_req` immediately (asynchronously); the transaction is abandoned.
- `stall` = (IDLE ∧ `req_valid`) ∨ BUS. It is combinational and low in RESP, so the PC advances on the RESP edge.
- Request accepted at edge 0: `mem_req` is high from edge 1.
- `mem_ack` sampled at edge N: `rsp_valid` is high in the cycle after edge N.
- Best-case latency, acknowledge in the first BUS cycle: request-to-`rsp_valid` = 2 cycles.
- Error without a bus access: `rsp_valid` one cycle after acceptance.
- `mem_ack` arriving on the same edge the counter reaches `TIMEOUT_CYCLES`: the acknowledge wins, with no error.
- Back-to-back accesses: one idle cycle (RESP→IDLE) minimum between transactions.

## Configuration
- Feature: misaligned-access trapping, controlled by `LSU_MISALIGN_TRAP_EN`.
- Misaligned means LH, LHU or SH with addr[0]=1, or LW or SW with addr[1:0]≠0.
- Defined: a misaligned access goes IDLE→RESP with `err`=1 and `rsp_rdata`=0; `mem_req` never rises.
- Undefined: the offending low address bits are ignored and the access proceeds aligned.
  - Half accesses use addr[1] only.
  - Word accesses use address bits [31:2] only.
  - No error is raised.

## Test plan
- LW, addr 0x0000_0100, `mem_ack` on the 3rd BUS cycle with `mem_rdata` 0xDEADBEEF → `mem_addr` 0x100, `mem_be` 1111, `rsp_rdata` 0xDEADBEEF, `stall` high for 4 cycles.
- LB addr 0x103 with `mem_rdata` 0x80123456 → `rsp_rdata` 0xFFFFFF80; LBU same → 0x00000080; LH addr 0x102 → 0xFFFF8012.
- SB addr 0x102, `req_wdata` 0x000000AB → `mem_we`=1, `mem_addr` 0x100, `mem_be` 0100, `mem_wdata` 0xABABABAB, `rsp_rdata` 0.
- LH addr 0x101: with the macro → `err`=1 one cycle after acceptance, `mem_req` never high; without the macro → `mem_be` 0011, normal completion.
- `TIMEOUT_CYCLES`=4, no `mem_ack` → `mem_req` high for exactly 4 cycles, then `rsp_valid`=`err`=1 with `rsp_rdata` 0; an ack on the 4th cycle completes normally instead.
- `n_rst` low during BUS → `mem_req`, `stall` and `rsp_valid` drop to 0 immediately; after release with `req_valid`=0 the block stays in IDLE.
